// File: rtl/axi_stream_skid_buffer.sv
// AXI4-Stream register slice: two-entry skid buffer with registered TVALID, TREADY and payload.
// Also exports the buffer occupancy and free-running downstream beat/packet counters.
module axi_stream_skid_buffer #(
   parameter int BYTE_WIDTH  = 4,
   parameter int ID_WIDTH    = 1,
   parameter int DEST_WIDTH  = 1,
   parameter int USER_WIDTH  = 1,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic [8*BYTE_WIDTH-1:0] s_tdata,
   input  logic [BYTE_WIDTH-1:0]   s_tstrb,
   input  logic [BYTE_WIDTH-1:0]   s_tkeep,
   input  logic                    s_tlast,
   input  logic [ID_WIDTH-1:0]     s_tid,
   input  logic [DEST_WIDTH-1:0]   s_tdest,
   input  logic [USER_WIDTH-1:0]   s_tuser,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic [8*BYTE_WIDTH-1:0] m_tdata,
   output logic [BYTE_WIDTH-1:0]   m_tstrb,
   output logic [BYTE_WIDTH-1:0]   m_tkeep,
   output logic                    m_tlast,
   output logic [ID_WIDTH-1:0]     m_tid,
   output logic [DEST_WIDTH-1:0]   m_tdest,
   output logic [USER_WIDTH-1:0]   m_tuser,
   output logic [1:0]              occupancy,
   output logic [COUNT_WIDTH-1:0]  beat_count,
   output logic [COUNT_WIDTH-1:0]  packet_count
);

   localparam int PW = 10*BYTE_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   s_tready_q;
   logic [PW-1:0]          out_q, out_d;
   logic [PW-1:0]          skid_q, skid_d;
   logic [PW-1:0]          s_pay;
   logic [COUNT_WIDTH-1:0] beat_q, beat_d;
   logic [COUNT_WIDTH-1:0] pkt_q, pkt_d;
   logic                   s_acc, m_acc;
   logic                   load_out, load_skid, out_from_skid;

   assign s_pay = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
   assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_q;

   assign s_tready     = s_tready_q;
   assign m_tvalid     = (state_q != EMPTY);
   assign occupancy    = 2'(state_q);
   assign beat_count   = beat_q;
   assign packet_count = pkt_q;

   assign s_acc = s_tvalid && s_tready_q;
   assign m_acc = m_tvalid && m_tready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= EMPTY;
         s_tready_q <= 1'b0;
         out_q      <= '0;
         skid_q     <= '0;
         beat_q     <= '0;
         pkt_q      <= '0;
      end else begin
         state_q    <= state_d;
         // s_tready is the registered "skid entry free" flag of the next state
         s_tready_q <= (state_d != FULL);
         out_q      <= out_d;
         skid_q     <= skid_d;
         beat_q     <= beat_d;
         pkt_q      <= pkt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (s_acc) state_d = ONE;
         ONE: begin
            if (s_acc && !m_acc)      state_d = FULL;
            else if (!s_acc && m_acc) state_d = EMPTY;
         end
         FULL:    if (m_acc) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      unique case (state_q)
         EMPTY: load_out = s_acc;
         ONE: begin
            load_out  = s_acc && m_acc;
            load_skid = s_acc && !m_acc;
         end
         FULL: begin
            load_out      = m_acc;
            out_from_skid = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      out_d  = out_q;
      skid_d = skid_q;
      beat_d = beat_q;
      pkt_d  = pkt_q;
      if (load_out)  out_d  = out_from_skid ? skid_q : s_pay;
      if (load_skid) skid_d = s_pay;
      if (m_acc) begin
         beat_d = beat_q + COUNT_WIDTH'(1);
         if (m_tlast) pkt_d = pkt_q + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_axi_stream_skid_buffer.sv
// Self-checking bench for axi_stream_skid_buffer: a FIFO scoreboard of accepted beats predicts
// payload, occupancy, handshakes and counters every cycle across directed and random traffic.
module tb_axi_stream_skid_buffer;

   localparam int BW       = 4;
   localparam int IDW      = 1;
   localparam int DW       = 1;
   localparam int UW       = 1;
   localparam int CW       = 4;
   localparam int PW       = 10*BW + 1 + IDW + DW + UW;
   localparam int LAST_BIT = IDW + DW + UW;

   typedef logic [PW-1:0] pay_t;

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic            s_tvalid = 1'b0;
   logic            s_tready;
   logic [8*BW-1:0] s_tdata;
   logic [BW-1:0]   s_tstrb, s_tkeep;
   logic            s_tlast;
   logic [IDW-1:0]  s_tid;
   logic [DW-1:0]   s_tdest;
   logic [UW-1:0]   s_tuser;
   logic            m_tvalid;
   logic            m_tready = 1'b0;
   logic [8*BW-1:0] m_tdata;
   logic [BW-1:0]   m_tstrb, m_tkeep;
   logic            m_tlast;
   logic [IDW-1:0]  m_tid;
   logic [DW-1:0]   m_tdest;
   logic [UW-1:0]   m_tuser;
   logic [1:0]      occupancy;
   logic [CW-1:0]   beat_count, packet_count;

   pay_t s_pay = '0;
   pay_t m_pay;
   assign {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = s_pay;
   assign m_pay = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};

   axi_stream_skid_buffer #(
      .BYTE_WIDTH (BW),
      .ID_WIDTH   (IDW),
      .DEST_WIDTH (DW),
      .USER_WIDTH (UW),
      .COUNT_WIDTH(CW)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tdata     (s_tdata),
      .s_tstrb     (s_tstrb),
      .s_tkeep     (s_tkeep),
      .s_tlast     (s_tlast),
      .s_tid       (s_tid),
      .s_tdest     (s_tdest),
      .s_tuser     (s_tuser),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tdata     (m_tdata),
      .m_tstrb     (m_tstrb),
      .m_tkeep     (m_tkeep),
      .m_tlast     (m_tlast),
      .m_tid       (m_tid),
      .m_tdest     (m_tdest),
      .m_tuser     (m_tuser),
      .occupancy   (occupancy),
      .beat_count  (beat_count),
      .packet_count(packet_count)
   );

   always #5 aclk = ~aclk;

   pay_t          q[$];
   int unsigned   vectors = 0;
   int unsigned   miscompares = 0;
   int unsigned   sready_lows = 0;
   logic [CW-1:0] exp_beats = '0;
   logic [CW-1:0] exp_pkts = '0;
   bit            rst_done = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic pay_t mk(input int unsigned d, input bit last);
      pay_t p;
      p = pay_t'({$urandom, $urandom});
      p[PW-1 -: 8*BW] = d[8*BW-1:0];
      p[LAST_BIT]     = last;
      return p;
   endfunction

   // One clock cycle: drive at the falling edge, check against the model, update it, cross the rising edge.
   task automatic step(input bit tv, input pay_t p, input bit mr, output bit acc);
      bit   sr_exp, m_acc;
      pay_t front;
      @(negedge aclk);
      s_tvalid = tv;
      s_pay    = p;
      m_tready = mr;
      sr_exp = rst_done && aresetn && (q.size() < 2);
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
      check("s_tready", 64'(s_tready), 64'(sr_exp));
      check("beat_count", 64'(beat_count), 64'(exp_beats));
      check("packet_count", 64'(packet_count), 64'(exp_pkts));
      if (q.size() != 0) check("payload", 64'(m_pay), 64'(q[0]));
      if (!aresetn) check("rst_payload", 64'(m_pay), 64'd0);
      if (!s_tready) sready_lows++;
      m_acc = (q.size() != 0) && mr;
      acc   = tv && sr_exp;
      if (m_acc) begin
         front = q.pop_front();
         exp_beats++;
         if (front[LAST_BIT]) exp_pkts++;
      end
      if (acc) q.push_back(p);
      @(posedge aclk);
      if (aresetn) rst_done = 1'b1;
   endtask

   task automatic apply_reset(input int unsigned cycles);
      bit dummy;
      #2 aresetn = 1'b0;
      #1;
      check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_s_tready", 64'(s_tready), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_beat_count", 64'(beat_count), 64'd0);
      check("rst_packet_count", 64'(packet_count), 64'd0);
      q.delete();
      exp_beats = '0;
      exp_pkts  = '0;
      rst_done  = 1'b0;
      for (int unsigned i = 0; i < cycles; i++) step(1'b1, mk(8'hEE, 1'b0), 1'b0, dummy);
      #2 aresetn = 1'b1;
      step(1'b1, mk(8'hEE, 1'b0), 1'b0, dummy);
   endtask

   task automatic drain(input string tag);
      bit dummy;
      for (int unsigned i = 0; i < 6 && q.size() != 0; i++) step(1'b0, '0, 1'b1, dummy);
      step(1'b0, '0, 1'b1, dummy);
      check(tag, 64'(q.size()), 64'd0);
   endtask

   initial begin
      bit          acc;
      int unsigned d;

      // Reset held with s_tvalid high, then released mid-cycle
      for (int unsigned i = 0; i < 3; i++) step(1'b1, mk(8'hEE, 1'b0), 1'b1, acc);
      #2 aresetn = 1'b1;
      step(1'b1, mk(0, 1'b0), 1'b1, acc);
      check("release_no_accept", 64'(acc), 64'd0);

      // Streaming 0..7, tlast on the last beat
      sready_lows = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         step(1'b1, mk(i, i == 7), 1'b1, acc);
         check("stream_accept", 64'(acc), 64'd1);
      end
      drain("stream_drained");
      #1;
      check("stream_beats", 64'(beat_count), 64'd8);
      check("stream_packets", 64'(packet_count), 64'd1);
      check("stream_sready_lows", 64'(sready_lows), 64'd0);

      // Backpressure: five stalled cycles under continuous input
      d = 16;
      for (int unsigned i = 0; i < 2; i++) begin step(1'b1, mk(d, 1'b0), 1'b1, acc); if (acc) d++; end
      for (int unsigned i = 0; i < 5; i++) begin step(1'b1, mk(d, 1'b0), 1'b0, acc); if (acc) d++; end
      #1;
      check("bp_occupancy", 64'(occupancy), 64'd2);
      check("bp_s_tready", 64'(s_tready), 64'd0);
      for (int unsigned i = 0; i < 6; i++) begin step(1'b1, mk(d, 1'b0), 1'b1, acc); if (acc) d++; end
      drain("bp_drained");

      // Single-cycle stall: s_tready drops for exactly one cycle
      sready_lows = 0;
      for (int unsigned i = 0; i < 3; i++) begin step(1'b1, mk(d, 1'b0), 1'b1, acc); if (acc) d++; end
      step(1'b1, mk(d, 1'b0), 1'b0, acc); if (acc) d++;
      for (int unsigned i = 0; i < 5; i++) begin step(1'b1, mk(d, 1'b0), 1'b1, acc); if (acc) d++; end
      check("stall_sready_lows", 64'(sready_lows), 64'd1);
      drain("stall_drained");

      // Mid-operation reset with the buffer full
      for (int unsigned i = 0; i < 3; i++) step(1'b1, mk(d + i, 1'b1), 1'b0, acc);
      #1;
      check("full_before_reset", 64'(occupancy), 64'd2);
      apply_reset(2);
      step(1'b1, mk(32'hA5, 1'b0), 1'b0, acc);
      check("post_rst_accept", 64'(acc), 64'd1);
      #1;
      check("post_rst_first", 64'(m_tdata), 64'hA5);
      drain("post_rst_drained");

      // Counter wrap with 4-bit counters: 17 single-beat packets
      apply_reset(1);
      d = 0;
      for (int unsigned i = 0; i < 40 && d < 17; i++) begin
         step(1'b1, mk(d, 1'b1), 1'b1, acc);
         if (acc) d++;
      end
      drain("wrap_drained");
      #1;
      check("wrap_beats", 64'(beat_count), 64'd1);
      check("wrap_packets", 64'(packet_count), 64'd1);

      // Random valid/ready traffic
      d = 0;
      for (int unsigned i = 0; i < 10000; i++) begin
         step($urandom_range(0, 9) < 7, mk(d, $urandom_range(0, 3) == 0), $urandom_range(0, 9) < 6, acc);
         if (acc) d++;
      end
      drain("random_drained");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_stream_skid_buffer.md
# axi_stream_skid_buffer

Fully registered AXI4-Stream register slice (two-entry skid buffer) between an upstream master and a downstream slave. It breaks every combinational path on TVALID, TREADY and payload while sustaining one beat per cycle. Its master port drives the downstream slave port and must satisfy the team's AXI-Stream slave-port property set. It also exports beat and packet counters for debug and status.

## Interface
- BYTE_WIDTH, 4: TDATA bytes; TSTRB/TKEEP width; must be ≥1
- ID_WIDTH, 1: TID width; must be ≥1; tie unused inputs to 0
- DEST_WIDTH, 1: TDEST width; must be ≥1
- USER_WIDTH, 1: TUSER width; must be ≥1
- COUNT_WIDTH, 32: width of beat/packet counters
- aclk  in  1  clock; all logic rising-edge
- aresetn  in  1  reset; asynchronous assert, active-low
- s_tvalid, s_tready  in/out  1  upstream handshake
- s_tdata  in  8*BYTE_WIDTH; s_tstrb, s_tkeep  in  BYTE_WIDTH; s_tlast  in  1
- s_tid  in  ID_WIDTH; s_tdest  in  DEST_WIDTH; s_tuser  in  USER_WIDTH
- m_tvalid, m_tready  out/in  1  downstream handshake
- m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  widths as s_*
- occupancy  out  2  beats held (0..2)
- beat_count  out  COUNT_WIDTH  downstream transfers since reset
- packet_count  out  COUNT_WIDTH  downstream transfers with m_tlast=1 since reset

## Operation
- Storage: output register (OUT) drives m_*; skid register (SKID) holds one extra beat. Payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser}, stored and forwarded unmodified.
- s_tready is registered: s_tready = !SKID valid and not in reset. m_tvalid = OUT valid.
- s_acc = s_tvalid && s_tready; m_acc = m_tvalid && m_tready.
- FSM:
  - EMPTY (occ 0): s_acc → OUT←s, ONE.
  - ONE (occ 1): s_acc && m_acc → OUT←s, stay ONE. s_acc && !m_acc → SKID←s, FULL. !s_acc && m_acc → EMPTY. Otherwise hold.
  - FULL (occ 2, s_tready=0): m_acc → OUT←SKID, ONE. Otherwise hold.
- OUT loads only when OUT is empty or m_acc. Payload on m_* is therefore stable while m_tvalid && !m_tready, and m_tvalid never falls without m_acc.
- FIFO order is preserved. Beats are never dropped or duplicated.
- beat_count += 1 on m_acc. packet_count += 1 on m_acc && m_tlast. Both wrap modulo 2^COUNT_WIDTH with no saturation.
- No payload checking. TSTRB/TKEEP legality is the upstream's responsibility and is forwarded as-is.

## Timing
- Reset (aresetn=0, takes effect immediately):
  - m_tvalid=0, s_tready=0, occupancy=0, both counters=0.
  - All m_* payload outputs=0. Both storage entries are invalidated.
- Mid-operation reset discards held beats without handshake. Counters restart at 0.
- s_tready rises at the first aclk edge sampling aresetn=1. m_tvalid can first rise at the edge after the first s_acc, so it is never asserted during or at the deassertion edge of reset.
- Latency: a beat accepted at edge N appears on m_* after edge N (one cycle). Added latency is 0 when the buffer is already ONE and streaming.
- Throughput: 1 beat/cycle with m_tready=1. After a single m_tready=0 stall cycle under continuous input, s_tready drops for exactly one cycle (the FULL state).
- Simultaneous s_acc and m_acc in ONE: occupancy unchanged, counters increment.
- FULL blocks input only through s_tready=0, so s_acc cannot occur in FULL.
- occupancy, beat_count and packet_count are registered and reflect state after the last edge.

## Test plan
- Reset release: hold aresetn=0 for 3 cycles with s_tvalid=1 → m_tvalid=0 and s_tready=0 throughout; s_tready=1 at the first edge after release; first beat appears on m_* one edge after s_acc.
- Streaming: send 8 beats (tdata 0..7, tlast on beat 7) with m_tready=1 → m_* emits 0..7 on consecutive cycles at 1-cycle latency; beat_count=8, packet_count=1; s_tready stays 1.
- Backpressure: continuous input, m_tready=0 for 5 cycles → occupancy reaches 2, s_tready=0, m_tdata stable across all 5 cycles; on release, order is preserved with no loss or duplication.
- Single-cycle stall: m_tready low for 1 cycle mid-stream → s_tready low for exactly 1 cycle; output sequence is unbroken and in order.
- Mid-operation reset: assert aresetn=0 with occupancy=2 → m_tvalid, s_tready and occupancy go to 0 immediately and counters read 0; after release, the next beat out is the first new beat.
- Wrap and random: COUNT_WIDTH=4, 17 single-beat packets → beat_count=1, packet_count=1; random valid/ready over 10k cycles with a scoreboard plus the slave-port property set on m_* → no mismatch or property failure.
